// File: rtl/uart_txs_pkg.sv
// uart_txs_pkg
//   Shared definitions for the multi-byte UART transmitter.
//   - state_t   : packet sequencer states
//   - FRAME_LEN : bits per 8N1 frame (start + 8 data + stop)
//   - baud_div  : clocks per bit, truncated
package uart_txs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FRAME_LEN = 10;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_txs_if.sv
// uart_txs_if
//   Request/data/status bundle of the multi-byte UART transmitter.
//   uart_tx_req   level request from the client
//   idats         packet word, captured when the transmitter leaves IDLE
//   uart_txs_done one-cycle end-of-packet strobe
//   uarttx        serial line, idle high
//   master: client side, slave: transmitter side.
interface uart_txs_if #(
  parameter int DATA_W = 16
);
  logic              uart_tx_req;
  logic [DATA_W-1:0] idats;
  logic              uart_txs_done;
  logic              uarttx;

  modport master (
    output uart_tx_req, idats,
    input  uart_txs_done, uarttx
  );

  modport slave (
    input  uart_tx_req, idats,
    output uart_txs_done, uarttx
  );
endinterface

// File: rtl/uart_txs_byte_tx.sv
// uart_byte_tx
//   8N1 byte serialiser. A start pulse loads din and begins a frame on the
//   next clock; each bit lasts BIT_CYC clocks. start is honoured even during
//   the last stop-bit cycle so frames can be chained without an idle gap.
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   start in  load din and begin a frame
//   din   in  byte to send (LSB first)
//   tx    out registered serial line
//   busy  out frame in progress
//   done  out high during the last clock of the stop bit
module uart_byte_tx
  import uart_txs_pkg::*;
#(
  parameter int BIT_CYC = 86
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_LEN - 1);

  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             busy_q;
  logic             tx_q;
  logic             bit_end;

  assign bit_end = busy_q && (bit_cnt == CNT_LAST);
  assign done    = bit_end && (bit_idx == IDX_LAST);
  assign busy    = busy_q;
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else if (start) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift_q <= din;
      busy_q  <= 1'b1;
      tx_q    <= 1'b0;
    end else if (busy_q) begin
      if (bit_end) begin
        bit_cnt <= '0;
        if (bit_idx == IDX_LAST) begin
          busy_q  <= 1'b0;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          // Leaving d7 enters the stop bit; otherwise shift out the next data bit.
          if (bit_idx == 4'd8) begin
            tx_q <= 1'b1;
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end
        end
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_txs_top.sv
// uart_txs_top
//   Captures a DATA_W word on request and sends it as DATA_W/8 chained 8N1
//   frames, most significant byte first, then pulses uart_txs_done.
//   sys_clk in    clock
//   rst_n   in    synchronous reset, active HIGH
//   bus     slave uart_tx_req / idats in, uart_txs_done / uarttx out
//
//   state | meaning
//   IDLE  | line idle; sample req, capture idats on request
//   LOAD  | start the most significant byte
//   SEND  | frames on the line; chain next byte or finish
//   DONE  | one-cycle done strobe
module uart_txs_top
  import uart_txs_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 115_200,
  parameter int DATA_W   = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  uart_txs_if.slave   bus
);

  localparam int NBYTES  = DATA_W / 8;
  localparam int BIT_CYC = baud_div(CLK_FREQ, BAUD);
  localparam int IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NBYTES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  byte_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [7:0]        byte_data;
  logic              byte_start;
  logic              byte_busy;
  logic              byte_done;
  logic              tx_line;
  logic              done_c;

  always_ff @(posedge sys_clk) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.uart_tx_req) state_d = LOAD;
      LOAD: state_d = SEND;
      SEND: begin
        if (byte_done && (byte_idx == '0)) state_d = DONE;
        // Recovery only: the serialiser should never be idle while in SEND.
        else if (!byte_busy)               state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_start = 1'b0;
    sel_idx    = IDX_TOP;
    done_c     = 1'b0;
    case (state_q)
      LOAD: byte_start = 1'b1;
      SEND: begin
        // Chain the next byte into the last stop-bit cycle to avoid a gap.
        if (byte_done && (byte_idx != '0)) begin
          byte_start = 1'b1;
          sel_idx    = byte_idx - IDX_W'(1);
        end
      end
      DONE: done_c = 1'b1;
      default: ;
    endcase
    byte_data = data_q[8*int'(sel_idx) +: 8];
  end

  always_ff @(posedge sys_clk) begin
    if (rst_n) begin
      data_q   <= '0;
      byte_idx <= '0;
    end else begin
      if ((state_q == IDLE) && bus.uart_tx_req) data_q <= bus.idats;
      if (state_q == LOAD) byte_idx <= IDX_TOP;
      else if ((state_q == SEND) && byte_done && (byte_idx != '0))
        byte_idx <= byte_idx - IDX_W'(1);
    end
  end

  uart_byte_tx #(
    .BIT_CYC (BIT_CYC)
  ) u_byte_tx (
    .clk   (sys_clk),
    .rst   (rst_n),
    .start (byte_start),
    .din   (byte_data),
    .tx    (tx_line),
    .busy  (byte_busy),
    .done  (byte_done)
  );

  assign bus.uarttx        = tx_line;
  assign bus.uart_txs_done = done_c;

endmodule

// File: tb/tb_uart_txs_top.sv
// tb_uart_txs_top
//   Directed bench for uart_txs_top at 10 MHz / 115200 (86 clocks per bit).
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_txs_top;

  localparam int BIT_CYC = 86;
  localparam int PKT_CYC = 2 * 10 * BIT_CYC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_txs_if #(.DATA_W(16)) bus ();

  uart_txs_top #(
    .CLK_FREQ (10_000_000),
    .BAUD     (115_200),
    .DATA_W   (16)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] idats;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called on the negedge where the first start bit should be visible;
  // returns on the negedge where the done strobe should be visible.
  task automatic check_packet(input logic [15:0] w, input string nm);
    logic [19:0] exp_bits;
    bit early;
    exp_bits = {1'b1, w[7:0], 1'b0, 1'b1, w[15:8], 1'b0};
    early = 1'b0;
    chk({nm, "_start_edge"}, {31'd0, bus.uarttx}, 32'd0);
    for (int c = 0; c < PKT_CYC; c++) begin
      if (bus.uart_txs_done) early = 1'b1;
      if (c % BIT_CYC == BIT_CYC / 2)
        chk($sformatf("%s_bit%0d", nm, c / BIT_CYC), {31'd0, bus.uarttx},
            {31'd0, exp_bits[c / BIT_CYC]});
      @(negedge clk);
    end
    chk({nm, "_early_done"}, {31'd0, early}, 32'd0);
    chk({nm, "_done"}, {31'd0, bus.uart_txs_done}, 32'd1);
    chk({nm, "_line_at_done"}, {31'd0, bus.uarttx}, 32'd1);
  endtask

  task automatic idle_check(input int n, input string nm);
    bit line_low, done_hi;
    line_low = 1'b0;
    done_hi  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!bus.uarttx) line_low = 1'b1;
      if (bus.uart_txs_done) done_hi = 1'b1;
    end
    chk({nm, "_line_low"}, {31'd0, line_low}, 32'd0);
    chk({nm, "_done_seen"}, {31'd0, done_hi}, 32'd0);
  endtask

  // Pulse req for one clock starting at the current negedge; returns on the
  // negedge where the start bit should appear.
  task automatic req_pulse(input string nm);
    bus.uart_tx_req = 1'b1;
    @(negedge clk);
    bus.uart_tx_req = 1'b0;
    chk({nm, "_load_line"}, {31'd0, bus.uarttx}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cont_exp [3];
    cont_exp[0] = 16'h1234;
    cont_exp[1] = 16'h1235;
    cont_exp[2] = 16'h1236;

    vecs[0] = '{16'h1234, 8'h12, 8'h34};
    vecs[1] = '{16'h00FF, 8'h00, 8'hFF};
    vecs[2] = '{16'hA55A, 8'hA5, 8'h5A};
    vecs[3] = '{16'h8001, 8'h80, 8'h01};

    bus.uart_tx_req = 1'b0;
    bus.idats       = 16'h0000;

    // Reset held for three clocks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_line%0d", i), {31'd0, bus.uarttx}, 32'd1);
      chk($sformatf("rst_done%0d", i), {31'd0, bus.uart_txs_done}, 32'd0);
    end
    rst_n = 1'b0;
    idle_check(20, "post_rst_idle");

    // Single packets from the vector table.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      bus.idats = vecs[v].idats;
      req_pulse($sformatf("vec%0d", v));
      check_packet({vecs[v].exp_hi, vecs[v].exp_lo}, $sformatf("vec%0d", v));
      @(negedge clk);
      chk($sformatf("vec%0d_done_width", v), {31'd0, bus.uart_txs_done}, 32'd0);
      idle_check(10, $sformatf("vec%0d_idle", v));
    end

    // Continuous: req held, idats bumped on each done.
    @(negedge clk);
    bus.idats = 16'h1234;
    bus.uart_tx_req = 1'b1;
    @(negedge clk);
    chk("cont_load_line", {31'd0, bus.uarttx}, 32'd1);
    @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      check_packet(cont_exp[p], $sformatf("cont%0d", p));
      if (p < 2) begin
        bus.idats = bus.idats + 16'd1;
        @(negedge clk);
        chk($sformatf("cont%0d_gap1_line", p), {31'd0, bus.uarttx}, 32'd1);
        chk($sformatf("cont%0d_gap1_done", p), {31'd0, bus.uart_txs_done}, 32'd0);
        @(negedge clk);
        chk($sformatf("cont%0d_gap2_line", p), {31'd0, bus.uarttx}, 32'd1);
        @(negedge clk);
      end else begin
        bus.uart_tx_req = 1'b0;
      end
    end
    idle_check(200, "cont_end_idle");

    // Capture: idats changed mid-packet only affects the next packet.
    @(negedge clk);
    bus.idats = 16'h1111;
    req_pulse("cap0");
    fork
      check_packet(16'h1111, "cap0");
      begin
        repeat (500) @(negedge clk);
        bus.idats = 16'h2222;
      end
    join
    idle_check(5, "cap_gap");
    req_pulse("cap1");
    check_packet(16'h2222, "cap1");
    idle_check(10, "cap_idle");

    // Reset during byte 0 bit 3, then a fresh packet.
    @(negedge clk);
    bus.idats = 16'h5A3C;
    req_pulse("abort");
    repeat (260) @(negedge clk);
    chk("abort_pre_line", {31'd0, bus.uarttx}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_line", {31'd0, bus.uarttx}, 32'd1);
    chk("abort_done0", {31'd0, bus.uart_txs_done}, 32'd0);
    @(negedge clk);
    chk("abort_line_hold", {31'd0, bus.uarttx}, 32'd1);
    chk("abort_done1", {31'd0, bus.uart_txs_done}, 32'd0);
    rst_n = 1'b0;
    bus.idats = 16'h0F0F;
    req_pulse("after_abort");
    check_packet(16'h0F0F, "after_abort");
    idle_check(10, "after_abort_idle");

    // Req dropped during byte 1: packet completes, single done, then idle.
    @(negedge clk);
    bus.idats = 16'hC3E7;
    bus.uart_tx_req = 1'b1;
    @(negedge clk);
    chk("drop_load_line", {31'd0, bus.uarttx}, 32'd1);
    @(negedge clk);
    fork
      check_packet(16'hC3E7, "drop");
      begin
        repeat (900) @(negedge clk);
        bus.uart_tx_req = 1'b0;
      end
    join
    idle_check(300, "drop_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
